// File: rtl/gemm_pkg.sv
// Shared GEMM datapath types: adder-tree beat tags and buffered dot-product results.
package gemm_pkg;

   localparam int CHUNK_CNT_W = 16;
   localparam int GEMM_DATA_W = 32;

   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

   // Layout of one FIFO entry at the default datapath width: data above chunk count
   typedef struct packed {
      logic [GEMM_DATA_W-1:0] data;
      logic [CHUNK_CNT_W-1:0] chunks;
   } result_t;

endpackage

// File: rtl/sum_fifo.sv
// Synchronous FIFO with registered occupancy and first-word-fall-through head.
module sum_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     head_valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full       = (count == (AW+1)'(DEPTH));
   assign head_valid = (count != '0);
   assign do_push    = push & ~full;
   assign do_pop     = pop & head_valid;
   // Head reads as zero when empty so the result port is clean out of reset
   assign head       = head_valid ? mem[rptr] : '0;

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/partial_sum_accumulator.sv
// Tags adder-tree beats, accumulates chunk sums into dot-product results and
// buffers them behind valid/ready, issuing credit so the unstallable tree never overflows the FIFO.
module partial_sum_accumulator
   import gemm_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LAYER      = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic                          in_last,
   output logic                          in_ready,
   input  logic signed [DATA_WIDTH-1:0]  sum_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [DATA_WIDTH-1:0]  out_data,
   output logic [CHUNK_CNT_W-1:0]        out_chunks
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = DATA_WIDTH + CHUNK_CNT_W;

   function automatic logic [CHUNK_CNT_W-1:0] sat_inc(input logic [CHUNK_CNT_W-1:0] c);
      return (c == '1) ? c : c + CHUNK_CNT_W'(1);
   endfunction

   tag_t                          tag_p [1:LAYER];
   tag_t                          qual;
   logic                          rst_q;
   logic                          accept;
   logic                          push;
   logic                          pop;
   int                            inflight;
   logic [CW-1:0]                 fifo_count;
   logic signed [DATA_WIDTH-1:0]  acc;
   logic [CHUNK_CNT_W-1:0]        cnt;
   logic                          first;
   logic signed [DATA_WIDTH-1:0]  nxt_acc;
   logic [CHUNK_CNT_W-1:0]        nxt_cnt;
   logic [EW-1:0]                 push_data;
   logic [EW-1:0]                 head;

   always_ff @(posedge clk) begin
      rst_q <= rst;
   end

   // Credit counts results already buffered plus last beats still inside the tree
   always_comb begin
      inflight = 0;
      for (int i = 1; i <= LAYER; i++) begin
         if (tag_p[i].last) inflight = inflight + 1;
      end
   end

   assign in_ready = !rst && !rst_q && ((int'(fifo_count) + inflight) < FIFO_DEPTH);
   assign accept   = in_valid & in_ready;

   // Stage p1..pLAYER: tags travel in lockstep with the tree's data
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i <= LAYER; i++) tag_p[i] <= '0;
      end else begin
         tag_p[1] <= tag_t'{valid: accept, last: accept & in_last};
         for (int i = 2; i <= LAYER; i++) tag_p[i] <= tag_p[i-1];
      end
   end

   // Tree output stage: tag at depth LAYER qualifies sum_in
   assign qual      = tag_p[LAYER];
   assign nxt_acc   = first ? sum_in : acc + sum_in;
   assign nxt_cnt   = first ? CHUNK_CNT_W'(1) : sat_inc(cnt);
   assign push      = qual.valid & qual.last;
   assign push_data = {nxt_acc, nxt_cnt};

   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         cnt   <= '0;
         first <= 1'b1;
      end else if (qual.valid) begin
         if (qual.last) begin
            acc   <= '0;
            cnt   <= '0;
            first <= 1'b1;
         end else begin
            acc   <= nxt_acc;
            cnt   <= nxt_cnt;
            first <= 1'b0;
         end
      end
   end

   assign pop = out_valid & out_ready;

   sum_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .head       (head),
      .head_valid (out_valid),
      .count      (fifo_count)
   );

   assign out_data   = head[EW-1:CHUNK_CNT_W];
   assign out_chunks = head[CHUNK_CNT_W-1:0];

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Directed and randomized checks of partial_sum_accumulator with a LAYER-deep tree model on sum_in.
module tb_partial_sum_accumulator;

   localparam int DW    = 32;
   localparam int LAYER = 2;
   localparam int DEPTH = 4;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          in_valid  = 1'b0;
   logic          in_last   = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] sum_in;
   logic [DW-1:0] out_data;
   logic [15:0]   out_chunks;
   logic [DW-1:0] chunk   = '0;
   logic [DW-1:0] tree_p1 = '0;
   logic [DW-1:0] tree_p2 = '0;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   // Two-cycle adder tree stand-in: carries garbage freely, no valid
   always @(posedge clk) begin
      tree_p1 <= chunk;
      tree_p2 <= tree_p1;
   end
   assign sum_in = tree_p2;

   partial_sum_accumulator #(
      .DATA_WIDTH (DW),
      .LAYER      (LAYER),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .sum_in     (sum_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_chunks (out_chunks)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic v, input logic l, input logic [DW-1:0] d);
      in_valid = v;
      in_last  = l;
      chunk    = d;
      tick();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int            acc_n;
      logic [DW-1:0] d;
      logic          v;
      logic          l;
      logic [DW-1:0] q_data[$];
      logic [15:0]   q_cnt[$];
      logic [DW-1:0] m_acc;
      int            m_n;

      // Reset state
      repeat (2) tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_chunks", out_chunks, 0);
      rst = 1'b0;
      chk("rst_q_in_ready", in_ready, 0);
      tick();
      chk("post_rst_in_ready", in_ready, 1);

      // Single-chunk dot product: out_valid at accept+3
      send(1, 1, 7);
      chk("t1_lat1", out_valid, 0);
      send(0, 0, 32'hDEAD);
      chk("t1_lat2", out_valid, 0);
      send(0, 0, 32'hBEEF);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 7);
      chk("t1_chunks", out_chunks, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t1_popped", out_valid, 0);

      // Three chunks 5+10+20
      send(1, 0, 5);
      send(1, 0, 10);
      send(1, 1, 20);
      chk("t2_early0", out_valid, 0);
      send(0, 0, 99);
      chk("t2_early1", out_valid, 0);
      send(0, 0, 99);
      chk("t2_valid", out_valid, 1);
      chk("t2_data", out_data, 35);
      chk("t2_chunks", out_chunks, 3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t2_popped", out_valid, 0);

      // Credit: stream single-chunk results with the consumer stalled
      acc_n = 0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t3_ready_c%0d", k), in_ready, (k < 4) ? 1 : 0);
         d = 100 + acc_n;
         if (in_ready) acc_n++;
         send(1, 1, d);
      end
      send(0, 0, 0);
      chk("t3_accepted", acc_n, 4);
      chk("t3_full_valid", out_valid, 1);
      chk("t3_head0", out_data, 100);
      chk("t3_ready_full", in_ready, 0);
      out_ready = 1'b1;
      chk("t3_ready_popcycle", in_ready, 0);
      tick();
      chk("t3_ready_return", in_ready, 1);
      chk("t3_head1", out_data, 101);
      tick();
      chk("t3_head2", out_data, 102);
      tick();
      chk("t3_head3", out_data, 103);
      tick();
      chk("t3_drained", out_valid, 0);
      out_ready = 1'b0;

      // Wrap modulo 2^32
      send(1, 0, 32'hFFFF_FFFF);
      send(1, 1, 2);
      send(0, 0, 0);
      send(0, 0, 0);
      chk("t4_valid", out_valid, 1);
      chk("t4_data", out_data, 1);
      chk("t4_chunks", out_chunks, 2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset with a buffered result, partial acc=9 and two beats in flight
      send(1, 1, 50);
      send(0, 0, 0);
      send(0, 0, 0);
      chk("t5_buffered", out_valid, 1);
      send(1, 0, 4);
      send(1, 0, 5);
      send(1, 0, 6);
      send(1, 1, 7);
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      chunk    = 32'h1234;
      tick();
      chk("t5_rst_out_valid", out_valid, 0);
      chk("t5_rst_in_ready", in_ready, 0);
      rst = 1'b0;
      chk("t5_rst_q_in_ready", in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         send(0, 0, 32'hBAD0 + i);
         chk($sformatf("t5_garbage_c%0d", i), out_valid, 0);
      end
      chk("t5_ready_back", in_ready, 1);
      send(1, 1, 4);
      send(0, 0, 32'hBAD9);
      send(0, 0, 32'hBADA);
      chk("t5_valid", out_valid, 1);
      chk("t5_data", out_data, 4);
      chk("t5_chunks", out_chunks, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Random traffic against a scoreboard
      m_acc = '0;
      m_n   = 0;
      for (int c = 0; c < 400; c++) begin
         v         = ($urandom_range(0, 3) != 0);
         l         = ($urandom_range(0, 2) == 0);
         d         = $urandom;
         out_ready = ($urandom_range(0, 1) == 1);
         if (out_valid && out_ready) begin
            if (q_data.size() == 0) begin
               chk("t6_spurious", out_valid, 0);
            end else begin
               chk("t6_data", out_data, q_data.pop_front());
               chk("t6_chunks", out_chunks, q_cnt.pop_front());
            end
         end
         if (v && in_ready) begin
            m_acc = m_acc + d;
            m_n++;
            if (l) begin
               q_data.push_back(m_acc);
               q_cnt.push_back(16'(m_n));
               m_acc = '0;
               m_n   = 0;
            end
         end
         send(v, l, d);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (out_valid) begin
            if (q_data.size() == 0) begin
               chk("t6_drain_spurious", out_valid, 0);
            end else begin
               chk("t6_drain_data", out_data, q_data.pop_front());
               chk("t6_drain_chunks", out_chunks, q_cnt.pop_front());
            end
         end
         send(0, 0, $urandom);
      end
      chk("t6_queue_empty", q_data.size(), 0);
      chk("t6_out_idle", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
